// File: rtl/cache_cpu_ctrl.sv
// cache_cpu_ctrl: CPU-side controller for a 4-line direct-mapped snooping cache.
// The CPU request is latched in IDLE and looked up. Misses fetch the line
// (RM/WM) after writing back an Exclusive victim. Write hits on Shared lines
// issue an Invalidate first. A snoop port may rewrite any line's state.
// Optional feature macro: CACHE_STATS_EN (hit/miss counters, saturating at 255).
module cache_cpu_ctrl (
    input  logic       clock,
    input  logic       resetn,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [4:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_ready,
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic [1:0] bus_op,
    output logic       bus_wb,
    output logic [4:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    input  logic       bus_ack,
    input  logic       snoop_we,
    input  logic [1:0] snoop_idx,
    input  logic [1:0] snoop_state,
    output logic [7:0] hit_count,
    output logic [7:0] miss_count
);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WB_REQ, WB_WAIT, BUS_REQ, BUS_WAIT, DONE
    } state_e;

    localparam logic [1:0] LS_INVALID = 2'b00;
    localparam logic [1:0] LS_EXCL    = 2'b01;
    localparam logic [1:0] LS_SHARED  = 2'b10;

    localparam logic [1:0] OP_RM  = 2'b00;
    localparam logic [1:0] OP_INV = 2'b01;
    localparam logic [1:0] OP_WM  = 2'b10;

    state_e     state_q, state_d;
    logic       we_q;
    logic [4:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] rdata_q, rdata_d;
    logic [1:0] op_q, op_d;
    logic       wb_q, wb_d;
    logic [4:0] baddr_q, baddr_d;
    logic [7:0] bwdata_q, bwdata_d;

    logic [1:0] lstate_q [4];
    logic [2:0] ltag_q   [4];
    logic [7:0] ldata_q  [4];

    logic [1:0] idx;
    logic [2:0] tag;
    logic [1:0] line_state;
    logic [2:0] line_tag;
    logic [7:0] line_data;
    logic       hit;
    logic       snoop_conflict;

    logic       lw_en;
    logic [1:0] lw_state;
    logic [7:0] lw_data;

    assign idx            = addr_q[1:0];
    assign tag            = addr_q[4:2];
    assign line_state     = lstate_q[idx];
    assign line_tag       = ltag_q[idx];
    assign line_data      = ldata_q[idx];
    assign hit            = (line_state != LS_INVALID) && (line_tag == tag);
    assign snoop_conflict = snoop_we && (snoop_idx == idx);

    // Latch the CPU request; it is only sampled while idle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state_q == IDLE && cpu_req) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            we_q    <= cpu_we;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
        end
    end

    // Next-state, bus command and line-update decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d  = state_q;
        rdata_d  = rdata_q;
        op_d     = op_q;
        wb_d     = wb_q;
        baddr_d  = baddr_q;
        bwdata_d = bwdata_q;
        lw_en    = 1'b0;
        lw_state = LS_INVALID;
        lw_data  = wdata_q;
        case (state_q)
            IDLE: if (cpu_req) state_d = LOOKUP;
            LOOKUP: begin
                if (snoop_conflict) begin
                    state_d = LOOKUP;  // re-evaluate with the snooped state next cycle
                end else if (hit) begin
                    if (!we_q) begin
                        rdata_d = line_data;
                        state_d = DONE;
                    end else if (line_state == LS_EXCL) begin
                        lw_en    = 1'b1;
                        lw_state = LS_EXCL;
                        state_d  = DONE;
                    end else begin
                        op_d     = OP_INV;
                        wb_d     = 1'b0;
                        baddr_d  = addr_q;
                        bwdata_d = '0;
                        state_d  = BUS_REQ;
                    end
                end else if (line_state == LS_EXCL) begin
                    op_d     = OP_RM;
                    wb_d     = 1'b1;
                    baddr_d  = {line_tag, idx};
                    bwdata_d = line_data;
                    state_d  = WB_REQ;
                end else begin
                    op_d     = we_q ? OP_WM : OP_RM;
                    wb_d     = 1'b0;
                    baddr_d  = addr_q;
                    bwdata_d = '0;
                    state_d  = BUS_REQ;
                end
            end
            WB_REQ: if (bus_gnt) state_d = WB_WAIT;
            WB_WAIT: begin
                if (bus_ack) begin
                    op_d     = we_q ? OP_WM : OP_RM;
                    wb_d     = 1'b0;
                    baddr_d  = addr_q;
                    bwdata_d = '0;
                    state_d  = BUS_REQ;
                end
            end
            BUS_REQ: if (bus_gnt) state_d = BUS_WAIT;
            BUS_WAIT: begin
                if (bus_ack) begin
                    lw_en = 1'b1;
                    if (op_q == OP_RM) begin
                        lw_state = LS_SHARED;
                        lw_data  = bus_rdata;
                        rdata_d  = bus_rdata;
                    end else begin
                        lw_state = LS_EXCL;
                    end
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Controller state and registered bus command.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            rdata_q  <= '0;
            op_q     <= OP_RM;
            wb_q     <= 1'b0;
            baddr_q  <= '0;
            bwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            op_q     <= op_d;
            wb_q     <= wb_d;
            baddr_q  <= baddr_d;
            bwdata_q <= bwdata_d;
        end
    end

    // Cache line storage: snoop updates state, controller completion overrides it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the line array is reset on purpose; every line must start Invalid.
            for (int i = 0; i < 4; i++) begin
                lstate_q[i] <= LS_INVALID;
                ltag_q[i]   <= '0;
                ldata_q[i]  <= '0;
            end
        end else begin
            if (snoop_we) lstate_q[snoop_idx] <= snoop_state;
            // NOTE: the later non-blocking write to the same index wins, giving the controller priority.
            if (lw_en) begin
                lstate_q[idx] <= lw_state;
                ltag_q[idx]   <= tag;
                ldata_q[idx]  <= lw_data;
            end
        end
    end

    assign cpu_ready = (state_q == DONE);
    assign cpu_rdata = rdata_q;
    assign bus_req   = (state_q == WB_REQ) || (state_q == WB_WAIT) ||
                       (state_q == BUS_REQ) || (state_q == BUS_WAIT);
    assign bus_op    = bus_req ? op_q     : 2'b00;
    assign bus_wb    = bus_req ? wb_q     : 1'b0;
    assign bus_addr  = bus_req ? baddr_q  : 5'd0;
    assign bus_wdata = bus_req ? bwdata_q : 8'd0;

`ifdef CACHE_STATS_EN
    logic       hit_ev, miss_ev;
    logic [7:0] hit_cnt_q, miss_cnt_q;

    assign hit_ev  = (state_q == LOOKUP) && !snoop_conflict && hit;
    assign miss_ev = (state_q == LOOKUP) && !snoop_conflict && !hit;

    // Saturating statistics counters, one step per final lookup decision.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_ev && hit_cnt_q != 8'hFF)   hit_cnt_q  <= hit_cnt_q + 8'd1;
            if (miss_ev && miss_cnt_q != 8'hFF) miss_cnt_q <= miss_cnt_q + 8'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = 8'd0;
    assign miss_count = 8'd0;
`endif

endmodule
